// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: serial-to-parallel front end for the adder tree.
// Accepts one signed DATAW-bit sample per cycle and packs INPUTS_AMOUNT of them
// into a vector (lane 0 = first sample). The vector is closed early by s_last_i,
// and the unfilled lanes are zero-padded so the downstream sum is unchanged.
// Optional macro ADDER_TREE_FEEDER_DOUBLE_BUFFER_EN adds a separate output register
// so that filling can continue while the previous vector waits for m_ready_i.
`timescale 1ns/1ps
module adder_tree_feeder #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int DATAW         = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [DATAW-1:0]                   s_data_i,
  input  logic                               s_valid_i,
  input  logic                               s_last_i,
  output logic                               s_ready_o,
  output logic [DATAW-1:0]                   m_vec_o [INPUTS_AMOUNT],
  output logic [$clog2(INPUTS_AMOUNT+1)-1:0] m_count_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i
);
  localparam int            CW       = $clog2(INPUTS_AMOUNT+1);
  localparam int            IW       = $clog2(INPUTS_AMOUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(INPUTS_AMOUNT-1);

  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [DATAW-1:0] fill_q     [INPUTS_AMOUNT];
  logic [DATAW-1:0] fill_d     [INPUTS_AMOUNT];
  logic [DATAW-1:0] closed_vec [INPUTS_AMOUNT];
  logic             accept;
  logic             close;
  logic [CW-1:0]    close_cnt;

  assign accept    = s_valid_i && s_ready_o;
  assign close     = accept && (s_last_i || (wr_idx_q == LAST_IDX));
  assign close_cnt = CW'(wr_idx_q) + CW'(1);

  // Fill buffer after this cycle's sample lands; lanes above it read as zero.
  // Applying this on every accept means a close already carries its padding.
  always_comb begin
    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
      if (IW'(i) == wr_idx_q)     closed_vec[i] = s_data_i;
      else if (IW'(i) > wr_idx_q) closed_vec[i] = '0;
      else                        closed_vec[i] = fill_q[i];
    end
  end

`ifdef ADDER_TREE_FEEDER_DOUBLE_BUFFER_EN

  logic [DATAW-1:0] out_q [INPUTS_AMOUNT];
  logic [DATAW-1:0] out_d [INPUTS_AMOUNT];
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  logic             out_full_q, out_full_d;
  logic             fill_closed_q, fill_closed_d;
  logic             xfer;
  logic             out_free;

  assign xfer      = out_full_q && m_ready_i;
  assign out_free  = !out_full_q || xfer;
  // A closed fill buffer can only be waiting while the output is occupied.
  assign s_ready_o = !rst_i && !(fill_closed_q && out_full_q);
  assign m_valid_o = out_full_q;
  assign m_vec_o   = out_q;
  assign m_count_o = out_cnt_q;

  // Next state: fill buffer accepts, closed vectors move to the output slot
  // as soon as it is free (including the cycle it is being transferred).
  always_comb begin
    fill_d        = fill_q;
    wr_idx_d      = wr_idx_q;
    fill_cnt_d    = fill_cnt_q;
    fill_closed_d = fill_closed_q;
    out_d         = out_q;
    out_cnt_d     = out_cnt_q;
    out_full_d    = out_full_q;
    if (xfer) out_full_d = 1'b0;
    if (fill_closed_q) begin
      if (out_free) begin
        out_d         = fill_q;
        out_cnt_d     = fill_cnt_q;
        out_full_d    = 1'b1;
        fill_closed_d = 1'b0;
      end
    end else if (accept) begin
      fill_d   = closed_vec;
      wr_idx_d = wr_idx_q + IW'(1);
      if (close) begin
        wr_idx_d = '0;
        if (out_free) begin
          out_d      = closed_vec;
          out_cnt_d  = close_cnt;
          out_full_d = 1'b1;
        end else begin
          fill_closed_d = 1'b1;
          fill_cnt_d    = close_cnt;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_idx_q      <= '0;
      fill_cnt_q    <= '0;
      fill_closed_q <= 1'b0;
      out_cnt_q     <= '0;
      out_full_q    <= 1'b0;
      for (int i = 0; i < INPUTS_AMOUNT; i++) begin
        fill_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      wr_idx_q      <= wr_idx_d;
      fill_cnt_q    <= fill_cnt_d;
      fill_closed_q <= fill_closed_d;
      out_cnt_q     <= out_cnt_d;
      out_full_q    <= out_full_d;
      fill_q        <= fill_d;
      out_q         <= out_d;
    end
  end

`else

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The fill buffer doubles as the output register.
  assign s_ready_o = !rst_i && (state_q == FILL);
  assign m_valid_o = (state_q == HOLD);
  assign m_vec_o   = fill_q;
  assign m_count_o = cnt_q;

  // FILL collects samples until a close; HOLD presents the vector until taken.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          fill_d   = closed_vec;
          wr_idx_d = wr_idx_q + IW'(1);
          if (close) begin
            wr_idx_d = '0;
            cnt_d    = close_cnt;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (m_ready_i) state_d = FILL;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FILL;
      wr_idx_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < INPUTS_AMOUNT; i++) fill_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
    end
  end

`endif

endmodule

// File: doc/adder_tree_feeder.md
# adder_tree_feeder

Serial-to-parallel front end for the adder tree. It accepts signed DATAW-bit samples one per cycle over a valid/ready stream and packs them into an INPUTS_AMOUNT-wide vector. It presents that vector, with a lane count, to the first `adder_tree_layer` over a second valid/ready handshake. Short vectors, terminated by `s_last_i`, are zero-padded, which is neutral for the downstream sum.

## Interface
- `INPUTS_AMOUNT`, 8: vector lanes; even, ≥ 2.
- `DATAW`, 8: sample width, two's complement.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `s_data_i`  in  DATAW  input sample.
- `s_valid_i`  in  1  sample valid.
- `s_last_i`  in  1  final sample of the current vector; qualified by `s_valid_i`.
- `s_ready_o`  out  1  feeder can accept a sample.
- `m_vec_o`  out  `[DATAW-1:0] [INPUTS_AMOUNT]` (unpacked array)  packed vector; lane 0 holds the first sample accepted.
- `m_count_o`  out  `$clog2(INPUTS_AMOUNT+1)`  number of real (non-padded) lanes, 1..INPUTS_AMOUNT.
- `m_valid_o`  out  1  vector valid.
- `m_ready_i`  in  1  downstream accepts the vector.

## Operation
- **Input accept:** a sample is accepted on an edge where `s_valid_i && s_ready_o`. It is written to lane `wr_idx`, and `wr_idx` increments.
- **Vector close:** a vector closes on the accept that fills lane INPUTS_AMOUNT-1, or on any accept with `s_last_i=1`, whichever comes first.
  - On close, lanes above the last written lane are forced to 0.
  - `m_count_o` is set to `wr_idx+1`.
  - `wr_idx` returns to 0.
- **`s_last_i` on the final lane:** a close, identical to a plain full close.
- **`s_last_i` without `s_valid_i`:** ignored.
- **Output hold:** `m_vec_o` and `m_count_o` stay stable while `m_valid_o=1 && m_ready_i=0`.
- **Output transfer:** the vector transfers on an edge where `m_valid_o && m_ready_i`.
- **Single-buffer FSM** (macro absent):
  - FILL: `s_ready_o=1`, `m_valid_o=0`. A close moves to HOLD.
  - HOLD: `s_ready_o=0`, `m_valid_o=1`. A transfer moves to FILL.
- **Width rule:** samples are stored unmodified; no extension or arithmetic.

## Timing
- **Reset values:**
  - While `rst_i=1`: `s_ready_o=0`.
  - First cycle after reset: `m_valid_o=0`, `m_vec_o` all lanes 0, `m_count_o=0`, `wr_idx=0`, state FILL.
  - `s_ready_o=1` from the first cycle after deassertion.
- **Latency:** `m_valid_o` rises the cycle after the closing accept.
  - Single buffer: minimum INPUTS_AMOUNT+1 cycles per full vector.
- **Reset mid-operation:** the partially filled vector and any pending output are discarded; no vector is emitted. Outputs return to their reset values the next cycle.
- **`m_ready_i` held high:** a transfer occurs the first cycle `m_valid_o` is high.
  - Single buffer: `s_ready_o` returns high the cycle after the transfer.

## Configuration
- **`ADDER_TREE_FEEDER_DOUBLE_BUFFER_EN` defined:**
  - Adds a separate output register and a pending flag `out_full`.
  - The fill buffer keeps accepting while the output register is occupied.
  - On close, the fill buffer copies to the output register if `!out_full`, or if a transfer happens in the same cycle. Otherwise the closed fill buffer waits with `s_ready_o=0` until the output frees.
  - `s_ready_o = !(fill_closed && out_full)`.
  - A close and a transfer on the same edge load the new vector with no bubble, so sustained throughput is one full vector per INPUTS_AMOUNT cycles.
- **Macro absent:** single-buffer FILL/HOLD behaviour as in Operation.

## Test plan
- **Reset:** assert `rst_i` 3 cycles with `s_valid_i=1` → `s_ready_o=0` throughout reset; `m_valid_o=0`; `m_vec_o` all 0; no sample captured.
- **Full vector:** stream 10, -3, 127, 1, -128, -1, 50, -50 with `m_ready_i=1`.
  - → `m_valid_o` high exactly one cycle after the 8th accept.
  - → lanes equal the inputs in order; `m_count_o=8`.
  - → downstream `adder_tree_layer` outputs 7, 128, -129, 0.
- **Short vector:** stream 5, -7, 3 with `s_last_i` on the 3rd → lanes 5, -7, 3, 0, 0, 0, 0, 0; `m_count_o=3`.
  - Also: a single sample -1 with `s_last_i` → `m_count_o=1`, lane 0 = 0xFF, other lanes 0.
- **Backpressure:** hold `m_ready_i=0` for 20 cycles after a close.
  - → `m_vec_o` and `m_count_o` stable.
  - → single buffer: `s_ready_o=0`.
  - → double buffer: exactly 8 further samples accepted, then `s_ready_o=0`.
  - Release `m_ready_i` → both vectors delivered in order.
- **Reset mid-fill:** accept 4 samples, pulse `rst_i` one cycle, then stream 8 samples of value 1.
  - → exactly one vector is emitted, all lanes 1, `m_count_o=8`.
- **Random traffic:** 500 random samples with random `s_valid_i`, `s_last_i` and `m_ready_i` → scoreboard matches every lane, zero-pad and count, with no loss or duplication. Run once with the macro defined and once without.
